rv32im_bpu: RTL and testbench
=============================

RV32IM_BPU -- requirements
Module: rv32im_bpu

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all PC/target buses.
REQ-002 Parameter ENTRIES, default 16, number of BTB entries; SHALL be a power of two, at least 2; IDX=log2(ENTRIES).
REQ-003 Parameter CNT_WIDTH, default 16, width of the mispredict statistics counter.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 fetch_pc_i  in  ADDR_WIDTH  PC being fetched, looked up every cycle.
REQ-007 pred_hit_o  out  1  valid tag match for fetch_pc_i (combinational).
REQ-008 pred_taken_o  out  1  hit AND counter MSB set (combinational).
REQ-009 pred_target_o  out  ADDR_WIDTH  stored target if pred_taken_o, else fetch_pc_i+4.
REQ-010 res_valid_i  in  1  a branch/jump resolved in execute this cycle.
REQ-011 res_pc_i  in  ADDR_WIDTH  PC of the resolved instruction.
REQ-012 res_conditional_i  in  1  1=conditional branch, 0=jal/jalr.
REQ-013 res_taken_i  in  1  actual outcome.
REQ-014 res_target_i  in  ADDR_WIDTH  actual computed target.
REQ-015 res_pred_taken_i  in  1  prediction carried down the pipe.
REQ-016 res_pred_target_i  in  ADDR_WIDTH  predicted next PC carried down the pipe.
REQ-017 flush_i  in  1  invalidate all BTB entries.
REQ-018 mispredict_o  out  1  registered; pulse one cycle after a mispredicted resolution.
REQ-019 redirect_pc_o  out  ADDR_WIDTH  registered; correct next PC, valid when mispredict_o=1.
REQ-020 mispredict_cnt_o  out  CNT_WIDTH  registered count of mispredictions.

Function
REQ-021 Index = pc[IDX+1:2]; tag = pc[ADDR_WIDTH-1:IDX+2]; pc[1:0] ignored.
REQ-022 Each entry holds valid bit, tag, target, 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-023 Lookup SHALL be combinational from registered array; same-cycle update to the same index SHALL NOT affect it (read-before-write).
REQ-024 On res_valid_i with hit: conditional -> counter +1 if taken (sat 11), -1 if not (sat 00); unconditional -> counter set 11; target overwritten with res_target_i only when taken.
REQ-025 On res_valid_i with miss: allocate (overwrite) only if res_taken_i; valid=1, tag, target=res_target_i, counter=10 if conditional, 11 if unconditional; not-taken misses SHALL leave the entry unchanged.
REQ-026 Actual next PC = res_taken_i ? res_target_i : res_pc_i+4 (modulo 2^ADDR_WIDTH).
REQ-027 Mispredict = res_valid_i AND (res_pred_taken_i != res_taken_i OR (res_taken_i AND res_pred_target_i != res_target_i)).
REQ-028 mispredict_o/redirect_pc_o SHALL register mispredict/actual next PC with one-cycle latency; mispredict_o=0 when res_valid_i=0; redirect_pc_o holds its last value otherwise.
REQ-029 mispredict_cnt_o SHALL increment on each mispredict and saturate at all-ones; flush_i SHALL NOT clear it.
REQ-030 flush_i SHALL clear all valid bits next edge; if flush_i and res_valid_i coincide, flush wins and no allocation/update occurs, but mispredict_o and the counter still update.
REQ-031 pred_target_o wrap: fetch_pc_i+4 SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-032 rst_i SHALL asynchronously clear all valid bits, set all counters 01, and drive mispredict_o=0, redirect_pc_o=0, mispredict_cnt_o=0; tags/targets need not reset.
REQ-033 Reset asserted mid-update SHALL discard that update; first update after deassertion applies on the following rising edge.

Verification
REQ-034 After reset, fetch_pc_i=0x100 -> pred_hit_o=0, pred_taken_o=0, pred_target_o=0x104.
REQ-035 res_valid_i, pc 0x100, conditional, taken, target 0x200, pred_taken 0 -> next cycle mispredict_o=1, redirect_pc_o=0x200, cnt=1; then fetch 0x100 -> hit, taken, target 0x200.
REQ-036 Counter walk on 0x100: two not-taken resolves -> 10->01->00, pred_taken_o=0; third not-taken stays 00; two taken -> 10, pred_taken_o=1.
REQ-037 Alias: allocate 0x100 then taken resolve at 0x140 (same index, ENTRIES=16) -> fetch 0x100 misses, 0x140 hits.
REQ-038 flush_i with coincident taken resolve at 0x180 -> all entries invalid, 0x180 misses, mispredict_o still reflects the resolve.
REQ-039 Correct prediction (pred taken, target matches) -> mispredict_o=0, cnt unchanged; fetch_pc_i=0xFFFFFFFC miss -> pred_target_o=0x0.

Source files
------------

// File: rtl/rv32im_bpu.sv
// rtl/rv32im_bpu.sv - direct-mapped branch target buffer with 2-bit counters
//
// Purpose: predicts taken/target for the fetch PC from a direct-mapped BTB,
// trains the BTB from execute-stage resolutions, and reports mispredictions.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   fetch_pc_i              PC looked up every cycle
//   pred_hit_o/taken_o      combinational tag hit / taken prediction
//   pred_target_o           predicted next PC (target or fetch_pc_i+4)
//   res_*_i                 resolved branch/jump information from execute
//   flush_i                 invalidates every BTB entry
//   mispredict_o            registered mispredict pulse
//   redirect_pc_o           registered correct next PC
//   mispredict_cnt_o        saturating mispredict count
module rv32im_bpu #(
  parameter int ADDR_WIDTH = 32,
  parameter int ENTRIES    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] fetch_pc_i,
  output logic                  pred_hit_o,
  output logic                  pred_taken_o,
  output logic [ADDR_WIDTH-1:0] pred_target_o,
  input  logic                  res_valid_i,
  input  logic [ADDR_WIDTH-1:0] res_pc_i,
  input  logic                  res_conditional_i,
  input  logic                  res_taken_i,
  input  logic [ADDR_WIDTH-1:0] res_target_i,
  input  logic                  res_pred_taken_i,
  input  logic [ADDR_WIDTH-1:0] res_pred_target_i,
  input  logic                  flush_i,
  output logic                  mispredict_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt_o
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            cnt_q    [ENTRIES];

  logic                  mispredict_q, mispredict_d;
  logic [ADDR_WIDTH-1:0] redirect_q, redirect_d;
  logic [CNT_WIDTH-1:0]  mis_cnt_q, mis_cnt_d;

  // Lookup reads only registered state, so a same-cycle update is not seen.
  logic [IDX-1:0]   fidx;
  logic [TAG_W-1:0] ftag;
  assign fidx = fetch_pc_i[IDX+1:2];
  assign ftag = fetch_pc_i[ADDR_WIDTH-1:IDX+2];

  always_comb begin
    pred_hit_o    = valid_q[fidx] && (tag_q[fidx] == ftag);
    pred_taken_o  = pred_hit_o && cnt_q[fidx][1];
    pred_target_o = pred_taken_o ? target_q[fidx] : fetch_pc_i + ADDR_WIDTH'(4);
  end

  // Resolution side
  logic [IDX-1:0]   ridx;
  logic [TAG_W-1:0] rtag;
  logic             res_hit, upd_en, alloc, train, wr_target, mis;
  logic [1:0]       cnt_d;
  logic [ADDR_WIDTH-1:0] actual_pc;

  assign ridx = res_pc_i[IDX+1:2];
  assign rtag = res_pc_i[ADDR_WIDTH-1:IDX+2];

  always_comb begin
    res_hit   = valid_q[ridx] && (tag_q[ridx] == rtag);
    // A coincident flush suppresses all training of the table.
    upd_en    = res_valid_i && !flush_i;
    alloc     = upd_en && !res_hit && res_taken_i;
    train     = upd_en && res_hit;
    wr_target = alloc || (train && res_taken_i);

    cnt_d = cnt_q[ridx];
    if (alloc) begin
      cnt_d = res_conditional_i ? 2'b10 : 2'b11;
    end else if (train) begin
      if (!res_conditional_i) begin
        cnt_d = 2'b11;
      end else if (res_taken_i) begin
        cnt_d = (cnt_q[ridx] == 2'b11) ? 2'b11 : cnt_q[ridx] + 2'd1;
      end else begin
        cnt_d = (cnt_q[ridx] == 2'b00) ? 2'b00 : cnt_q[ridx] - 2'd1;
      end
    end

    actual_pc = res_taken_i ? res_target_i : res_pc_i + ADDR_WIDTH'(4);
    mis = res_valid_i &&
          ((res_pred_taken_i != res_taken_i) ||
           (res_taken_i && (res_pred_target_i != res_target_i)));

    mispredict_d = mis;
    redirect_d   = res_valid_i ? actual_pc : redirect_q;
    mis_cnt_d    = (mis && !(&mis_cnt_q)) ? mis_cnt_q + CNT_WIDTH'(1) : mis_cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b01;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      mis_cnt_q    <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= '0;
      end else if (alloc) begin
        valid_q[ridx] <= 1'b1;
      end
      if (alloc || train) cnt_q[ridx] <= cnt_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  // Tags and targets carry no reset; gating on rst_i keeps a write that
  // races reset from landing, even though valid is cleared anyway.
  always_ff @(posedge clk_i) begin
    if (!rst_i && alloc)     tag_q[ridx]    <= rtag;
    if (!rst_i && wr_target) target_q[ridx] <= res_target_i;
  end

  assign mispredict_o     = mispredict_q;
  assign redirect_pc_o    = redirect_q;
  assign mispredict_cnt_o = mis_cnt_q;

endmodule

// File: tb/tb_rv32im_bpu.sv
// tb/tb_rv32im_bpu.sv - scoreboard testbench for rv32im_bpu
module tb_rv32im_bpu;

  localparam int AW = 32;
  localparam int NE = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] fetch_pc = 32'h100;
  logic          pred_hit, pred_taken;
  logic [AW-1:0] pred_target;
  logic          res_valid = 0, res_cond = 0, res_taken = 0, res_ptaken = 0, flush = 0;
  logic [AW-1:0] res_pc = 0, res_target = 0, res_ptarget = 0;
  logic          mispredict;
  logic [AW-1:0] redirect_pc;
  logic [CW-1:0] mis_cnt;

  rv32im_bpu #(.ADDR_WIDTH(AW), .ENTRIES(NE), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .fetch_pc_i(fetch_pc),
    .pred_hit_o(pred_hit), .pred_taken_o(pred_taken), .pred_target_o(pred_target),
    .res_valid_i(res_valid), .res_pc_i(res_pc), .res_conditional_i(res_cond),
    .res_taken_i(res_taken), .res_target_i(res_target),
    .res_pred_taken_i(res_ptaken), .res_pred_target_i(res_ptarget),
    .flush_i(flush), .mispredict_o(mispredict), .redirect_pc_o(redirect_pc),
    .mispredict_cnt_o(mis_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct { int due; bit hit; bit tk; logic [AW-1:0] tgt; } pred_t;
  typedef struct { int due; bit mis; logic [AW-1:0] rd; int cnt; bit chkrd; } reg_t;
  pred_t pq[$];
  reg_t  rq[$];

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a table of entries indexed by word address modulo NE.
  bit            mv   [NE];
  logic [AW-1:0] mtag [NE];
  logic [AW-1:0] mtgt [NE];
  int            mcnt [NE];
  int            exp_cnt;

  function automatic int idx_of(input logic [AW-1:0] pc);
    return int'((pc / 4) % NE);
  endfunction

  function automatic logic [AW-1:0] tag_of(input logic [AW-1:0] pc);
    return pc / (4 * NE);
  endfunction

  function automatic pred_t model_pred(input logic [AW-1:0] pc);
    pred_t p;
    int i = idx_of(pc);
    p.due = cyc;
    p.hit = mv[i] && (mtag[i] == tag_of(pc));
    p.tk  = p.hit && (mcnt[i] >= 2);
    p.tgt = p.tk ? mtgt[i] : pc + 32'd4;
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin mv[i] = 0; mcnt[i] = 1; end
    exp_cnt = 0;
  endtask

  // One cycle of stimulus; expectations are queued for the monitor.
  task automatic step(input logic [AW-1:0] fpc, input bit rv, input bit cond, input bit tk,
                      input logic [AW-1:0] rpc, input logic [AW-1:0] rtgt,
                      input bit ptk, input logic [AW-1:0] ptgt, input bit fl);
    reg_t r;
    bit mis, hit;
    int i;
    @(posedge clk); #1;
    fetch_pc = fpc; res_valid = rv; res_cond = cond; res_taken = tk; res_pc = rpc;
    res_target = rtgt; res_ptaken = ptk; res_ptarget = ptgt; flush = fl;
    pq.push_back(model_pred(fpc));
    mis = rv && ((ptk != tk) || (tk && ptgt != rtgt));
    if (mis && exp_cnt < (1 << CW) - 1) exp_cnt++;
    r.due = cyc + 1; r.mis = mis; r.rd = tk ? rtgt : rpc + 32'd4; r.cnt = exp_cnt; r.chkrd = mis;
    rq.push_back(r);
    i = idx_of(rpc);
    hit = mv[i] && (mtag[i] == tag_of(rpc));
    if (fl) begin
      for (int k = 0; k < NE; k++) mv[k] = 0;
    end else if (rv) begin
      if (hit) begin
        if (!cond) mcnt[i] = 3;
        else if (tk) mcnt[i] = (mcnt[i] < 3) ? mcnt[i] + 1 : 3;
        else mcnt[i] = (mcnt[i] > 0) ? mcnt[i] - 1 : 0;
        if (tk) mtgt[i] = rtgt;
      end else if (tk) begin
        mv[i] = 1; mtag[i] = tag_of(rpc); mtgt[i] = rtgt; mcnt[i] = cond ? 2 : 3;
      end
    end
  endtask

  task automatic idle(input logic [AW-1:0] fpc);
    step(fpc, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
  endtask

  // Called between edges right after reset deasserts.
  task automatic push_reset_checks();
    reg_t r;
    res_valid = 0; flush = 0; fetch_pc = 32'h100;
    pq.push_back(model_pred(32'h100));
    r.due = cyc; r.mis = 0; r.rd = 32'h0; r.cnt = 0; r.chkrd = 1;
    rq.push_back(r);
  endtask

  pred_t mp;
  reg_t  mr;
  always @(negedge clk) begin
    while (pq.size() > 0 && pq[0].due == cyc) begin
      mp = pq.pop_front();
      chk("pred_hit", {31'b0, pred_hit}, {31'b0, mp.hit});
      chk("pred_taken", {31'b0, pred_taken}, {31'b0, mp.tk});
      chk("pred_target", pred_target, mp.tgt);
    end
    while (rq.size() > 0 && rq[0].due == cyc) begin
      mr = rq.pop_front();
      chk("mispredict", {31'b0, mispredict}, {31'b0, mr.mis});
      chk("mis_cnt", {28'b0, mis_cnt}, mr.cnt[AW-1:0]);
      if (mr.chkrd) chk("redirect_pc", redirect_pc, mr.rd);
    end
  end

  task automatic rand_step();
    logic [AW-1:0] fpc, rpc, tgt, ptgt;
    bit rv, cond, tk, ptk, fl;
    pred_t p;
    fpc = 32'h100 + 32'h40 * $urandom_range(0, 5) + 4 * $urandom_range(0, 3);
    rpc = 32'h100 + 32'h40 * $urandom_range(0, 5) + 4 * $urandom_range(0, 3);
    if ($urandom_range(0, 30) == 0) fpc = 32'hFFFF_FFFC;
    if ($urandom_range(0, 30) == 0) rpc = 32'hFFFF_FFFC;
    case ($urandom_range(0, 3))
      0: tgt = 32'h200;
      1: tgt = 32'h300;
      2: tgt = 32'h400;
      default: tgt = $urandom & 32'hFFFF_FFFC;
    endcase
    rv   = $urandom_range(0, 2) != 0;
    cond = $urandom_range(0, 3) != 0;
    tk   = cond ? $urandom_range(0, 1) == 1 : 1'b1;
    fl   = $urandom_range(0, 60) == 0;
    p = model_pred(rpc);
    if ($urandom_range(0, 3) != 0) begin ptk = p.tk; ptgt = p.tgt; end
    else begin ptk = $urandom_range(0, 1) == 1; ptgt = ptk ? tgt : rpc + 32'd4; end
    step(fpc, rv, cond, tk, rpc, tgt, ptk, ptgt, fl);
  endtask

  initial begin
    model_reset();
    #12 rst = 1'b0;
    @(posedge clk); #1;
    push_reset_checks();

    // Allocate on taken miss; same-cycle fetch still misses.
    step(32'h100, 1, 1, 1, 32'h100, 32'h200, 0, 32'h104, 0);
    idle(32'h100);
    // Counter walk 10 -> 01 -> 00 -> 00, then 01 -> 10.
    step(32'h100, 1, 1, 0, 32'h100, 32'h200, 1, 32'h200, 0);
    step(32'h100, 1, 1, 0, 32'h100, 32'h200, 0, 32'h104, 0);
    step(32'h100, 1, 1, 0, 32'h100, 32'h200, 0, 32'h104, 0);
    step(32'h100, 1, 1, 1, 32'h100, 32'h200, 0, 32'h104, 0);
    step(32'h100, 1, 1, 1, 32'h100, 32'h200, 0, 32'h104, 0);
    idle(32'h100);
    idle(32'hFFFF_FFFC);
    // Alias at same index.
    step(32'h100, 1, 1, 1, 32'h140, 32'h300, 0, 32'h144, 0);
    idle(32'h100);
    idle(32'h140);
    // Flush wins over coincident resolve.
    step(32'h140, 1, 1, 1, 32'h180, 32'h400, 0, 32'h184, 1);
    idle(32'h180);
    idle(32'h140);
    // Jump allocation, then correct prediction.
    step(32'h100, 1, 0, 1, 32'h100, 32'h200, 0, 32'h104, 0);
    step(32'h100, 1, 0, 1, 32'h100, 32'h200, 1, 32'h200, 0);
    idle(32'h100);

    repeat (1500) rand_step();

    // Reset while a taken resolve is being presented.
    @(posedge clk); #1;
    fetch_pc = 32'h104; res_valid = 1; res_cond = 1; res_taken = 1; res_pc = 32'h104;
    res_target = 32'h500; res_ptaken = 0; res_ptarget = 32'h108; flush = 0;
    #1 rst = 1'b1;
    #1 model_reset(); pq.delete(); rq.delete();
    #1 rst = 1'b0;
    push_reset_checks();
    idle(32'h104);
    step(32'h104, 1, 1, 1, 32'h104, 32'h500, 0, 32'h108, 0);
    idle(32'h104);

    repeat (1500) rand_step();
    idle(32'h100);
    repeat (3) @(posedge clk);
    #2;
    if (pq.size() != 0 || rq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d pred and %0d reg expectations left, expected 0", pq.size(), rq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
